// File: rtl/regbank_ctx_seq_pkg.sv
// Shared types and constants for the register-bank
// context save/restore sequencer.
package regbank_ctx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } state_t;

  localparam int REG_FIRST  = 1;
  localparam int REG_LAST   = 31;
  localparam int WORD_BYTES = 4;

  // Context slot n lives at base + 4*n; wraps mod 2^32
  function automatic logic [31:0] slot_addr(
    input logic [31:0] base,
    input logic [4:0]  idx
  );
    return base + 32'(idx) * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/regbank_ctx_seq_if.sv
// Trap/core, register-bank and data-memory signals
// of the context sequencer.
interface regbank_ctx_seq_if #(
  parameter int DATA_W = 32
);
  logic              iSave;
  logic              iRestore;
  logic [31:0]       iBaseAddr;
  logic              oBusy;
  logic              oCoreStall;
  logic              oDone;
  logic              oError;
  logic [4:0]        oRegSel;
  logic [DATA_W-1:0] iRegData;
  logic              oRegWrite;
  logic [4:0]        oRegWriteAddr;
  logic [DATA_W-1:0] oRegWriteData;
  logic              oMemReq;
  logic              oMemWrite;
  logic [31:0]       oMemAddr;
  logic [DATA_W-1:0] oMemWData;
  logic              iMemAck;
  logic [DATA_W-1:0] iMemRData;

  modport master (
    input  iSave, iRestore, iBaseAddr,
    input  iRegData, iMemAck, iMemRData,
    output oBusy, oCoreStall, oDone, oError,
    output oRegSel, oRegWrite,
    output oRegWriteAddr, oRegWriteData,
    output oMemReq, oMemWrite,
    output oMemAddr, oMemWData
  );

  modport slave (
    output iSave, iRestore, iBaseAddr,
    output iRegData, iMemAck, iMemRData,
    input  oBusy, oCoreStall, oDone, oError,
    input  oRegSel, oRegWrite,
    input  oRegWriteAddr, oRegWriteData,
    input  oMemReq, oMemWrite,
    input  oMemAddr, oMemWData
  );
endinterface

// File: rtl/regbank_ctx_seq.sv
// Walks x1..x31, saving them to or restoring them
// from a memory context area; stalls the core meanwhile.
module regbank_ctx_seq
  import regbank_ctx_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              iCLK,
  input logic              iCLR_n,
  regbank_ctx_seq_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          st;
  state_t          st_nx;
  logic [4:0]      idx;
  logic [WD_W-1:0] wd;
  logic [31:0]     base;
  logic            err;

  logic is_idle;
  logic busy;
  logic xfer;
  logic last;
  logic expire;
  logic waiting;
  logic start;

  assign is_idle = (st == IDLE);
  assign busy    = (st == SAVE) || (st == RESTORE);
  assign xfer    = busy && bus.iMemAck;
  assign last    = (idx == 5'(REG_LAST));
  assign start   = bus.iSave || bus.iRestore;

  // Watchdog hits TIMEOUT on this cycle's missing ack
  assign expire  = busy && !bus.iMemAck &&
                   (wd == WD_W'(TIMEOUT - 1));
  assign waiting = busy && !bus.iMemAck && !expire;

  always_ff @(posedge iCLK or negedge iCLR_n) begin
    if (!iCLR_n) begin
      st   <= IDLE;
      idx  <= 5'(REG_FIRST);
      wd   <= '0;
      base <= '0;
      err  <= 1'b0;
    end else begin
      st <= st_nx;
      unique case (1'b1)
        is_idle: begin
          if (start) begin
            base <= {bus.iBaseAddr[31:2], 2'b00};
            idx  <= 5'(REG_FIRST);
            wd   <= '0;
            err  <= 1'b0;
          end
        end
        xfer: begin
          idx <= idx + 5'd1;
          wd  <= '0;
        end
        expire:  err <= 1'b1;
        waiting: wd  <= wd + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (bus.iSave)
          st_nx = SAVE;
        else if (bus.iRestore)
          st_nx = RESTORE;
      end
      SAVE, RESTORE: begin
        if ((xfer && last) || expire)
          st_nx = DONE;
      end
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  logic is_save;
  logic is_rest;

  assign is_save = (st == SAVE);
  assign is_rest = (st == RESTORE);

  assign bus.oBusy      = busy;
  assign bus.oDone      = (st == DONE);
  assign bus.oCoreStall = busy || (st == DONE);
  assign bus.oError     = err;
  assign bus.oMemReq    = busy;
  assign bus.oMemWrite  = is_save;
  assign bus.oRegSel    = is_save ? idx : 5'd0;

  assign bus.oMemAddr =
    busy ? slot_addr(base, idx) : 32'd0;
  assign bus.oMemWData =
    is_save ? bus.iRegData : DATA_W'(0);

  assign bus.oRegWrite     = is_rest && bus.iMemAck;
  assign bus.oRegWriteAddr = is_rest ? idx : 5'd0;
  assign bus.oRegWriteData =
    is_rest ? bus.iMemRData : DATA_W'(0);

endmodule

// File: tb/tb_regbank_ctx_seq.sv
// Randomized and directed bench for regbank_ctx_seq
// against a transfer-level reference model.
module tb_regbank_ctx_seq;

  localparam int TMO = 8;

  logic iCLK   = 1'b0;
  logic iCLR_n = 1'b0;

  always #5 iCLK = ~iCLK;

  regbank_ctx_seq_if #(.DATA_W(32)) bus ();

  regbank_ctx_seq #(
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .iCLK  (iCLK),
    .iCLR_n(iCLR_n),
    .bus   (bus)
  );

  logic [31:0] bank [32];
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;

  int ack_wait  = 0;
  int ack_stop  = 1000;
  bit ack_rand  = 0;
  int waitcnt   = 0;
  int xfer      = 0;
  int busy_cyc  = 0;
  int done_cyc  = 0;
  logic [31:0] first_addr = '0;

  // Reference model: op in flight, next slot, stall count
  bit          m_act = 0;
  bit          m_sv  = 0;
  bit          m_dn  = 0;
  bit          m_er  = 0;
  int          m_n   = 1;
  int          m_w   = 0;
  logic [31:0] m_base = '0;

  logic        a;
  logic [31:0] ea;

  assign bus.iRegData = bank[bus.oRegSel];

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memrd(
    input logic [31:0] ad
  );
    if (mem.exists(ad))
      return mem[ad];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge iCLK or negedge iCLR_n) begin
    if (!iCLR_n) begin
      m_act  = 0;
      m_sv   = 0;
      m_dn   = 0;
      m_er   = 0;
      m_n    = 1;
      m_w    = 0;
      m_base = '0;
    end else if (m_dn) begin
      m_dn = 0;
    end else if (!m_act) begin
      if (bus.iSave || bus.iRestore) begin
        m_act  = 1;
        m_sv   = bus.iSave;
        m_n    = 1;
        m_w    = 0;
        m_er   = 0;
        m_base = bus.iBaseAddr & 32'hFFFF_FFFC;
      end
    end else if (bus.iMemAck) begin
      m_w = 0;
      if (m_n == 31) begin
        m_act = 0;
        m_dn  = 1;
      end else begin
        m_n++;
      end
    end else begin
      m_w++;
      if (m_w == TMO) begin
        m_act = 0;
        m_dn  = 1;
        m_er  = 1;
      end
    end
  end

  // Memory and bank environment
  always @(posedge iCLK) begin
    if (iCLR_n) begin
      if (bus.oMemReq && bus.iMemAck) begin
        if (xfer == 0)
          first_addr = bus.oMemAddr;
        if (bus.oMemWrite)
          mem[bus.oMemAddr] = bus.oMemWData;
        xfer++;
        waitcnt = 0;
      end else if (bus.oMemReq) begin
        waitcnt++;
      end
      if (bus.oRegWrite)
        bank[bus.oRegWriteAddr] = bus.oRegWriteData;
    end
  end

  always @(negedge iCLK) begin
    if (ack_rand)
      a = ($urandom_range(0, 2) != 0);
    else
      a = bus.oMemReq && (waitcnt >= ack_wait) &&
          (xfer < ack_stop);
    bus.iMemAck   = a;
    bus.iMemRData = mem.exists(bus.oMemAddr) ?
                    mem[bus.oMemAddr] : $urandom;
    #1;
    ea = m_base + 32'(m_n) * 32'd4;
    chk("busy", 32'(bus.oBusy), 32'(m_act));
    chk("done", 32'(bus.oDone), 32'(m_dn));
    chk("stall", 32'(bus.oCoreStall),
        32'(m_act | m_dn));
    chk("error", 32'(bus.oError), 32'(m_er));
    chk("memreq", 32'(bus.oMemReq), 32'(m_act));
    chk("memwrite", 32'(bus.oMemWrite),
        32'(m_act & m_sv));
    chk("regsel", 32'(bus.oRegSel),
        (m_act && m_sv) ? 32'(m_n) : 32'd0);
    if (m_act)
      chk("memaddr", bus.oMemAddr, ea);
    else
      chk("memaddr_idle", bus.oMemAddr, 32'd0);
    if (m_act && m_sv)
      chk("memwdata", bus.oMemWData, bank[m_n]);
    chk("regwrite", 32'(bus.oRegWrite),
        32'(m_act && !m_sv && bus.iMemAck));
    if (m_act && !m_sv && bus.iMemAck) begin
      chk("regwaddr", 32'(bus.oRegWriteAddr),
          32'(m_n));
      chk("regwdata", bus.oRegWriteData,
          bus.iMemRData);
    end
    if (bus.oBusy)
      busy_cyc++;
    if (bus.oDone)
      done_cyc++;
  end

  task automatic prep(
    input int aw,
    input int as,
    input bit ar
  );
    ack_wait = aw;
    ack_stop = as;
    ack_rand = ar;
    xfer     = 0;
    waitcnt  = 0;
    busy_cyc = 0;
    done_cyc = 0;
  endtask

  task automatic start(
    input bit          sv,
    input bit          rs,
    input logic [31:0] b
  );
    @(negedge iCLK);
    bus.iSave     = sv;
    bus.iRestore  = rs;
    bus.iBaseAddr = b;
    @(negedge iCLK);
    bus.iSave     = 0;
    bus.iRestore  = 0;
    bus.iBaseAddr = $urandom;
  endtask

  task automatic wait_done(input int lim);
    bit seen;
    seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge iCLK);
      #2;
      seen = bus.oDone;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic fill_bank_rand();
    bank[0] = '0;
    for (int n = 1; n < 32; n++)
      bank[n] = $urandom;
  endtask

  task automatic fill_mem(input logic [31:0] b);
    mem.delete();
    for (int n = 0; n < 32; n++)
      mem[b + 32'(n) * 32'd4] = 32'h5500 + 32'(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    bit found;
    bus.iSave     = 0;
    bus.iRestore  = 0;
    bus.iBaseAddr = '0;
    for (int n = 0; n < 32; n++)
      bank[n] = '0;
    repeat (2) @(negedge iCLK);
    #2;
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_error", 32'(bus.oError), 32'd0);
    chk("rst_memaddr", bus.oMemAddr, 32'd0);
    @(negedge iCLK);
    iCLR_n = 1;

    // Save, zero-wait ack
    for (int n = 1; n < 32; n++)
      bank[n] = 32'hA0 + 32'(n);
    mem.delete();
    prep(0, 1000, 0);
    start(1, 0, 32'h1001_0000);
    wait_done(100);
    chk("s1_busy", busy_cyc, 31);
    chk("s1_done", done_cyc, 1);
    chk("s1_err", 32'(bus.oError), 32'd0);
    chk("s1_cnt", mem.num(), 31);
    chk("s1_first", memrd(32'h1001_0004), 32'hA1);
    chk("s1_last", memrd(32'h1001_007C), 32'hBF);
    ok = 1;
    for (int n = 1; n < 32; n++)
      if (memrd(32'h1001_0000 + 32'(4 * n)) !==
          32'hA0 + 32'(n))
        ok = 0;
    chk("s1_mem", 32'(ok), 32'd1);

    // Restore, two wait cycles per transfer
    fill_mem(32'h2000_0000);
    fill_bank_rand();
    prep(2, 1000, 0);
    start(0, 1, 32'h2000_0000);
    wait_done(400);
    chk("r2_busy", busy_cyc, 93);
    chk("r2_done", done_cyc, 1);
    chk("r2_x0", bank[0], 32'd0);
    chk("r2_sp", bank[2], 32'h5502);
    ok = 1;
    for (int n = 1; n < 32; n++)
      if (bank[n] !== 32'h5500 + 32'(n))
        ok = 0;
    chk("r2_bank", 32'(ok), 32'd1);

    // Both requests: save wins; restore pulse ignored
    mem.delete();
    prep(1, 1000, 0);
    start(1, 1, 32'h1001_0003);
    repeat (3) @(negedge iCLK);
    bus.iRestore = 1;
    @(negedge iCLK);
    bus.iRestore = 0;
    wait_done(200);
    chk("s3_first", first_addr, 32'h1001_0004);
    chk("s3_data", memrd(32'h1001_0004), 32'h5501);
    chk("s3_cnt", mem.num(), 31);
    chk("s3_busy", busy_cyc, 62);

    // Address wrap-around
    fill_bank_rand();
    mem.delete();
    prep(0, 1000, 0);
    start(1, 0, 32'hFFFF_FFF0);
    wait_done(100);
    chk("w4_x1", memrd(32'hFFFF_FFF4), bank[1]);
    chk("w4_x4", memrd(32'h0000_0000), bank[4]);
    chk("w4_x31", memrd(32'h0000_006C), bank[31]);
    chk("w4_err", 32'(bus.oError), 32'd0);

    // Ack withheld from transfer 5 onward
    mem.delete();
    prep(0, 4, 0);
    start(1, 0, 32'h3000_0000);
    wait_done(100);
    chk("t5_err", 32'(bus.oError), 32'd1);
    chk("t5_wait", waitcnt, TMO);
    chk("t5_busy", busy_cyc, 4 + TMO);
    chk("t5_cnt", mem.num(), 4);
    chk("t5_x5", 32'(mem.exists(32'h3000_0014)),
        32'd0);
    repeat (3) @(negedge iCLK);
    #2;
    chk("t5_hold", 32'(bus.oError), 32'd1);
    prep(0, 1000, 0);
    start(1, 0, 32'h3000_0000);
    #2;
    chk("t5_clear", 32'(bus.oError), 32'd0);
    wait_done(100);
    chk("t5_err2", 32'(bus.oError), 32'd0);

    // Reset in the middle of a restore
    fill_mem(32'h4000_0000);
    fill_bank_rand();
    prep(0, 1000, 0);
    start(0, 1, 32'h4000_0000);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge iCLK);
      #2;
      found = m_act && (m_n == 10);
    end
    chk("r6_reach", 32'(found), 32'd1);
    iCLR_n = 0;
    #1;
    chk("r6_busy", 32'(bus.oBusy), 32'd0);
    chk("r6_stall", 32'(bus.oCoreStall), 32'd0);
    chk("r6_req", 32'(bus.oMemReq), 32'd0);
    chk("r6_wr", 32'(bus.oRegWrite), 32'd0);
    repeat (3) @(negedge iCLK);
    chk("r6_nodone", done_cyc, 0);
    chk("r6_x9", bank[9], 32'h5509);
    iCLR_n = 1;
    prep(0, 1000, 0);
    start(1, 0, 32'h5000_0000);
    wait_done(100);
    chk("r6_first", first_addr, 32'h5000_0004);
    chk("r6_busy2", busy_cyc, 31);

    // Random operations with random ack timing
    for (int t = 0; t < 10; t++) begin
      bit sv;
      logic [31:0] b;
      sv = 1'($urandom_range(0, 1));
      b  = $urandom;
      fill_bank_rand();
      fill_mem(b & 32'hFFFF_FFFC);
      prep(0, 1000, 1);
      start(sv, !sv, b);
      wait_done(600);
      chk("rnd_done", done_cyc, 1);
    end
    prep(0, 1000, 0);
    repeat (2) @(negedge iCLK);
    chk("x0_zero", bank[0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_ctx_seq.md
Name: regbank_ctx_seq

Overview:
- Context save/restore sequencer for the 32x32 CPU register bank.
- On a trap or context switch it walks registers x1..x31:
  - save: reads each register through one bank read port and writes it to memory at a base address;
  - restore: reads memory and writes each register through the bank write port.
- Stalls the core while active and sits between the register bank, the data-memory arbiter and the trap logic.

Parameters:
- DATA_W, 32, register and memory word width.
- TIMEOUT, 255, max cycles to wait for iMemAck on one transfer before aborting (must be ≥1).

Ports:
- iCLK  in  1  system clock, rising edge.
- iCLR_n  in  1  asynchronous active-low reset.
- iSave  in  1  start-save request, sampled in IDLE only.
- iRestore  in  1  start-restore request, sampled in IDLE only.
- iBaseAddr  in  32  context area base address, latched at start.
- oBusy  out  1  high in SAVE/RESTORE.
- oCoreStall  out  1  equals oBusy | oDone.
- oDone  out  1  one-cycle completion pulse.
- oError  out  1  last operation timed out; held until next start.
- oRegSel  out  5  bank read-port select; bank read is combinational.
- iRegData  in  DATA_W  bank read data for oRegSel.
- oRegWrite  out  1  bank write enable.
- oRegWriteAddr  out  5  bank write address.
- oRegWriteData  out  DATA_W  bank write data.
- oMemReq  out  1  memory request.
- oMemWrite  out  1  1 = write (save), 0 = read (restore).
- oMemAddr  out  32  word address.
- oMemWData  out  DATA_W  store data.
- iMemAck  in  1  transfer accepted/completed this cycle.
- iMemRData  in  DATA_W  load data, valid when iMemAck = 1.

Behaviour:
- Reset (iCLR_n low, asynchronous):
  - state = IDLE, index = 1, watchdog = 0, latched base = 0;
  - all outputs 0, including oError.
  - Reset mid-operation abandons the transfer with no oDone pulse; the bank is left partially written.
- IDLE:
  - iSave=1 → SAVE; otherwise iRestore=1 → RESTORE. Both high: save wins.
  - On start: base latched with bits [1:0] forced to 0; index = 1; watchdog = 0; oError cleared.
  - iSave/iRestore while not IDLE are ignored (no queuing).
- Addressing: oMemAddr = base + 4*index, modulo 2^32 (wrap-around allowed, no error).
- SAVE:
  - oMemReq=1, oMemWrite=1, oRegSel=index, oMemWData=iRegData (combinational).
  - Address and data stay stable until ack.
- RESTORE:
  - oMemReq=1, oMemWrite=0, oRegSel=0.
  - oRegWrite = iMemAck, oRegWriteAddr = index, oRegWriteData = iMemRData, all combinational; the bank captures on the clock edge ending the ack cycle.
- Handshake:
  - A transfer completes in any cycle with oMemReq & iMemAck at the rising edge. Zero-wait ack in the first cycle is legal.
  - On completion: index++ and watchdog = 0. index==31 at completion → DONE.
  - iMemAck while oMemReq=0 is ignored.
- Watchdog:
  - Increments each SAVE/RESTORE cycle without ack.
  - Reaching TIMEOUT → DONE with oError=1; oMemReq drops and no further transfers occur.
- DONE:
  - Lasts exactly one cycle: oDone=1, oBusy=0, all request/write outputs 0.
  - Then → IDLE. A start request present during DONE is ignored.
- x0 is never saved, restored or written. SP (x2) is handled like any other register.
- Latency with zero-wait ack: oBusy for 31 cycles, oDone on the 32nd cycle after the start edge.

Decomposition:
- Package regbank_ctx_pkg holds:
  - state enum IDLE/SAVE/RESTORE/DONE;
  - REG_FIRST=1, REG_LAST=31, WORD_BYTES=4.
- Single module; index counter and watchdog are inline, no sub-module is warranted.

Test Plan:
- Save, zero-wait ack, base 0x1001_0000, x1..x31 preloaded with 0xA0+n → 31 memory writes to 0x1001_0004..0x1001_007C with data 0xA0+n, oBusy 31 cycles, then a one-cycle oDone, oError=0.
- Restore, ack after 2 wait cycles per transfer, memory word n = 0x5500+n → bank x1..x31 = 0x5500+n, x0 = 0, 93 busy cycles, single oDone.
- iSave and iRestore both high in IDLE → save runs; pulsing iRestore mid-save has no effect; base 0x1001_0003 → first address 0x1001_0004.
- Base 0xFFFF_FFF0 save → addresses wrap: index 4 → 0x0000_0000, index 31 → 0x0000_006C, no error.
- Ack withheld from transfer 5 onward, TIMEOUT=8 → oMemReq drops after 8 waiting cycles, oDone pulses, oError=1 until next iSave.
- iCLR_n pulsed low during restore at index 10 → all outputs 0 immediately, no oDone, next iSave starts cleanly at index 1.
